// File: rtl/uart_rx_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_frontend
// Brief    : 8N1 UART receive front end. It has a two-flop synchronizer, an
//            oversampling baud divider, a receive FSM, and a holding register
//            that the consumer acknowledges. It reports framing errors and
//            overruns.
//            Optional build macro UART_RX_FIFO_EN replaces the single holding
//            register with a FIFO_DEPTH-entry receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frontend #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       rx_ack,
  input  logic       ovr_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int c_DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int c_DIV_W  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_TICK_W = $clog2(OVERSAMPLE);

  localparam logic [c_DIV_W-1:0]  c_DIV_MAX = c_DIV_W'(c_DIV - 1);
  localparam logic [c_TICK_W-1:0] c_HALF_M1 = c_TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TICK_W-1:0] c_OS_M1   = c_TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [c_DIV_W-1:0]    r_div;
  logic [c_TICK_W-1:0]   r_tick_cnt;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shreg;
  logic                  r_frame_err;
  logic                  r_overrun;
  logic                  w_rxs;
  logic                  w_tick;
  logic                  w_start_det;
  logic                  w_mid_start;
  logic                  w_bit_samp;
  logic                  w_deliver;
  logic                  w_ferr;
  logic                  w_drop;

  assign w_rxs       = r_sync2;
  assign w_tick      = (r_div == c_DIV_MAX);
  assign w_start_det = (r_state == S_IDLE) && !w_rxs;
  assign w_mid_start = (r_state == S_START) && w_tick && (r_tick_cnt == c_HALF_M1);
  assign w_bit_samp  = ((r_state == S_DATA) || (r_state == S_STOP)) && w_tick &&
                       (r_tick_cnt == c_OS_M1);

  // Bring the asynchronous line into the sysclk domain; idles high.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= UART_RX;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running baud-tick divider, re-phased on each start edge.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (w_start_det || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Tick counter positions the sample point within the current bit.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (w_start_det || w_mid_start || w_bit_samp) begin
      r_tick_cnt <= '0;
    end else if (w_tick && (r_state != S_IDLE) && (r_state != S_BREAK)) begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Data bits shift in LSB first; the bit counter tracks the eight data bits.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else if (w_mid_start) begin
      r_bit_cnt <= '0;
    end else if (w_bit_samp && (r_state == S_DATA)) begin
      r_shreg   <= {w_rxs, r_shreg[7:1]};
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state plus the delivery and framing-error strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_rxs) w_state_nxt = S_START;
      S_START: if (w_mid_start) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_samp && (r_bit_cnt == 3'd7)) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_bit_samp) begin
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
            w_deliver   = 1'b1;
          end else begin
            w_state_nxt = S_BREAK;
            w_ferr      = 1'b1;
          end
        end
      end
      S_BREAK: if (w_rxs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered one-cycle framing-error pulse.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_pop;
  logic               w_push;
  logic               w_full;

  assign w_full = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_pop  = rx_ack && (r_count != '0);
  assign w_push = w_deliver && (!w_full || w_pop);
  assign w_drop = w_deliver && w_full && !w_pop;

  // FIFO storage; cleared on reset so the head reads 0x00 when empty.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= r_shreg;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_data  = r_mem[r_rd_ptr];
  assign rx_valid = (r_count != '0);
`else
  logic [7:0] r_hold;
  logic       r_valid;
  logic       w_ack;
  logic       w_unused_cfg;

  assign w_unused_cfg = (FIFO_DEPTH > 0);
  assign w_ack  = rx_ack && r_valid;
  assign w_drop = w_deliver && r_valid && !w_ack;

  // Single holding register: a same-cycle ack frees the slot for a new byte.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_hold  <= '0;
      r_valid <= 1'b0;
    end else if (w_deliver && !w_drop) begin
      r_hold  <= r_shreg;
      r_valid <= 1'b1;
    end else if (w_ack) begin
      r_valid <= 1'b0;
    end
  end

  assign rx_data  = r_hold;
  assign rx_valid = r_valid;
`endif

  // Sticky overrun flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign rx_overrun = r_overrun;
  assign frame_err  = r_frame_err;
  assign rx_busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frontend
// Brief    : Directed scoreboard bench for uart_rx_frontend. It runs at a
//            scaled-up baud rate so that one bit lasts 96 sysclk cycles.
//            It honours UART_RX_FIFO_EN when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frontend;

  localparam int CLK_FREQ = 100000000;
  localparam int BAUD     = 1000000;
  localparam int OS       = 16;
  localparam int BITC     = (CLK_FREQ / (BAUD * OS)) * OS;

  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic       UART_RX = 1'b1;
  logic       rx_ack = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       frame_err;
  logic       rx_busy;

  int         total = 0;
  int         bad = 0;
  int         ferr_cnt = 0;
  int         f0;
  logic       auto_ack = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_frontend #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS),
    .FIFO_DEPTH(4)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .rx_ack    (rx_ack),
    .ovr_clr   (ovr_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_overrun(rx_overrun),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send_bit(input logic b);
    UART_RX = b;
    waitc(BITC);
  endtask

  // Start bit, eight data bits LSB first, then the stop bit (line left at stop level).
  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !rx_valid && !rx_ack) break;
      waitc(1);
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: count frame_err pulses; pop and compare each presented byte, then ack it.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge sysclk);
      if (frame_err) ferr_cnt++;
      if (!reset) begin
        rx_ack = 1'b0;
      end else if (rx_ack) begin
        rx_ack = 1'b0;
      end else if (rx_valid && auto_ack) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got=0x%0h expected=none", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_rx_data", rx_data, e);
        end
        rx_ack = 1'b1;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    waitc(5);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", rx_busy, 0);
    reset = 1'b1;
    waitc(BITC);

    // Frame 0x54 with delivery-latency window around 9.5 bit times
    exp_q.push_back(8'h54);
    fork
      send_frame(8'h54, 1'b1);
      begin
        waitc(905);
        check("lat_before", rx_valid, 0);
        waitc(20);
        check("lat_after", rx_valid, 1);
        check("t1_data", rx_data, 8'h54);
      end
    join
    check("t1_ferr", ferr_cnt, 0);
    auto_ack = 1'b1;
    drain("t1_drain");
    auto_ack = 1'b0;

    // Frame 0x0C after a two-bit idle gap
    waitc(2 * BITC);
    exp_q.push_back(8'h0C);
    send_frame(8'h0C, 1'b1);
    waitc(2);
    check("t2_valid", rx_valid, 1);
    check("t2_data", rx_data, 8'h0C);
    check("t2_overrun", rx_overrun, 0);
    auto_ack = 1'b1;
    drain("t2_drain");
    auto_ack = 1'b0;

    // Short low glitch on the idle line is rejected
    f0 = ferr_cnt;
    UART_RX = 1'b0;
    waitc(20);
    UART_RX = 1'b1;
    waitc(BITC);
    check("gl_busy", rx_busy, 0);
    check("gl_valid", rx_valid, 0);
    check("gl_ferr", ferr_cnt, f0);

    // Frame 0xA5 with a low stop bit, line then held low
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    waitc(BITC);
    check("brk_busy1", rx_busy, 1);
    waitc(2 * BITC);
    check("brk_busy2", rx_busy, 1);
    check("brk_ferr", ferr_cnt, f0 + 1);
    check("brk_valid", rx_valid, 0);
    UART_RX = 1'b1;
    waitc(4);
    check("brk_busy_end", rx_busy, 0);
    waitc(BITC);

    // Two frames with no acknowledge
`ifdef UART_RX_FIFO_EN
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h0C);
`else
    exp_q.push_back(8'h54);
`endif
    send_frame(8'h54, 1'b1);
    send_frame(8'h0C, 1'b1);
    waitc(2);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h54);
`ifdef UART_RX_FIFO_EN
    check("ovr_flag", rx_overrun, 0);
`else
    check("ovr_flag", rx_overrun, 1);
`endif
    ovr_clr = 1'b1;
    waitc(1);
    ovr_clr = 1'b0;
    check("ovr_clr", rx_overrun, 0);
    auto_ack = 1'b1;
    drain("ovr_drain");
    auto_ack = 1'b0;

    // Reset pulsed during data bit 4 of 0x54, then a full 0x0C frame
    waitc(BITC);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    UART_RX = 1'b1;
    waitc(40);
    check("mid_busy", rx_busy, 1);
    reset = 1'b0;
    waitc(2);
    check("mr_valid", rx_valid, 0);
    check("mr_data", rx_data, 0);
    check("mr_overrun", rx_overrun, 0);
    check("mr_ferr", frame_err, 0);
    check("mr_busy", rx_busy, 0);
    waitc(8);
    reset = 1'b1;
    waitc(2 * BITC);
    exp_q.push_back(8'h0C);
    auto_ack = 1'b1;
    send_frame(8'h0C, 1'b1);
    drain("mr_drain");
    check("total_ferr", ferr_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
